// File: rtl/systolic4_pkg.sv
// Shared widths, bus address map and controller state type for the 2x2 systolic array.
package systolic4_pkg;

  localparam int unsigned DataW    = 16;
  localparam int unsigned BufDepth = 256;
  localparam int unsigned BufAw    = 8;
  localparam int unsigned CntW     = 8;

  localparam logic [15:0] SYS_START_ADR = 16'hFFF0;
  localparam logic [15:0] SYS_MAX_CNTR  = 16'hFFF1;
  localparam logic [15:0] SYS_RUN_CNTR  = 16'hFFF2;
  localparam logic [15:0] SYS_C00_ADR   = 16'hFFF4;
  localparam logic [15:0] SYS_C01_ADR   = 16'hFFF5;
  localparam logic [15:0] SYS_C10_ADR   = 16'hFFF6;
  localparam logic [15:0] SYS_C11_ADR   = 16'hFFF7;

  // Buffer selector values in address bits [9:8].
  localparam logic [1:0] BUF_A0 = 2'd0;
  localparam logic [1:0] BUF_A1 = 2'd1;
  localparam logic [1:0] BUF_B0 = 2'd2;
  localparam logic [1:0] BUF_B1 = 2'd3;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} sys_state_e;

  // True for the operand-buffer window 0x0000-0x03FF.
  function automatic logic is_buf_adr(input logic [15:0] adr);
    return adr[15:10] == 6'd0;
  endfunction

endpackage

// File: rtl/systolic4_iobuf.sv
// Groups the four operand RAMs with bus write decode and host read mux.
module systolic4_iobuf
  import systolic4_pkg::*;
(
  input  logic             clk_i,
  input  logic             wen_i,
  input  logic [15:0]      wadr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [15:0]      radr_i,
  output logic [DataW-1:0] host_rdata_o,
  input  logic [BufAw-1:0] feed_adr_i,
  output logic [DataW-1:0] a0_o,
  output logic [DataW-1:0] a1_o,
  output logic [DataW-1:0] b0_o,
  output logic [DataW-1:0] b1_o
);

  logic [3:0]       we;
  logic [DataW-1:0] rd_a0, rd_a1, rd_b0, rd_b1;

  // Per-buffer write strobes from the window and selector bits.
  always_comb begin
    we = 4'b0000;
    if (wen_i && is_buf_adr(wadr_i)) begin
      we[wadr_i[9:8]] = 1'b1;
    end
  end

  // Host read data; zero outside the buffer window.
  always_comb begin
    host_rdata_o = '0;
    if (is_buf_adr(radr_i)) begin
      unique case (radr_i[9:8])
        BUF_A0:  host_rdata_o = rd_a0;
        BUF_A1:  host_rdata_o = rd_a1;
        BUF_B0:  host_rdata_o = rd_b0;
        BUF_B1:  host_rdata_o = rd_b1;
        default: host_rdata_o = '0;
      endcase
    end
  end

  systolic4_ram buf_a0 (
    .clk_i        (clk_i),
    .we_i         (we[0]),
    .waddr_i      (wadr_i[7:0]),
    .wdata_i      (wdata_i),
    .host_raddr_i (radr_i[7:0]),
    .host_rdata_o (rd_a0),
    .feed_raddr_i (feed_adr_i),
    .feed_rdata_o (a0_o)
  );

  systolic4_ram buf_a1 (
    .clk_i        (clk_i),
    .we_i         (we[1]),
    .waddr_i      (wadr_i[7:0]),
    .wdata_i      (wdata_i),
    .host_raddr_i (radr_i[7:0]),
    .host_rdata_o (rd_a1),
    .feed_raddr_i (feed_adr_i),
    .feed_rdata_o (a1_o)
  );

  systolic4_ram buf_b0 (
    .clk_i        (clk_i),
    .we_i         (we[2]),
    .waddr_i      (wadr_i[7:0]),
    .wdata_i      (wdata_i),
    .host_raddr_i (radr_i[7:0]),
    .host_rdata_o (rd_b0),
    .feed_raddr_i (feed_adr_i),
    .feed_rdata_o (b0_o)
  );

  systolic4_ram buf_b1 (
    .clk_i        (clk_i),
    .we_i         (we[3]),
    .waddr_i      (wadr_i[7:0]),
    .wdata_i      (wdata_i),
    .host_raddr_i (radr_i[7:0]),
    .host_rdata_o (rd_b1),
    .feed_raddr_i (feed_adr_i),
    .feed_rdata_o (b1_o)
  );

endmodule

// File: rtl/systolic4_pe.sv
// Processing element: registered a/b pass-through plus wrapping 16-bit MAC.
module systolic4_pe
  import systolic4_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DataW-1:0] a_i,
  input  logic [DataW-1:0] b_i,
  output logic [DataW-1:0] a_o,
  output logic [DataW-1:0] b_o,
  output logic [DataW-1:0] acc_o
);

  logic [DataW-1:0] a_q, b_q, acc_q;
  logic [DataW-1:0] prod;

  // Low half of the product is identical for signed and unsigned operands.
  assign prod = a_i * b_i;

  // Clear also flushes the pass-through registers so a new run starts clean.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
    end else if (en_i) begin
      a_q   <= a_i;
      b_q   <= b_i;
      acc_q <= acc_q + prod;
    end
  end

  assign a_o   = a_q;
  assign b_o   = b_q;
  assign acc_o = acc_q;

endmodule

// File: rtl/systolic4_ram.sv
// 256x16 operand RAM: host write port, registered array-side read port, host read tap.
module systolic4_ram
  import systolic4_pkg::*;
(
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [BufAw-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic [BufAw-1:0] host_raddr_i,
  output logic [DataW-1:0] host_rdata_o,
  input  logic [BufAw-1:0] feed_raddr_i,
  output logic [DataW-1:0] feed_rdata_o
);

  logic [DataW-1:0] ram [BufDepth];
  logic [DataW-1:0] feed_rdata_q;

  // Storage write and synchronous read for the array feed; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      ram[waddr_i] <= wdata_i;
    end
    feed_rdata_q <= ram[feed_raddr_i];
  end

  // Host side is registered once by the bus read register in the top level.
  assign host_rdata_o = ram[host_raddr_i];
  assign feed_rdata_o = feed_rdata_q;

endmodule

// File: rtl/systolic_4.sv
// 2x2 output-stationary systolic MAC array with operand buffers on the host ibus.
module systolic_4
  import systolic4_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,  // active-high synchronous reset despite the name
  input  logic        ren,
  input  logic [15:0] ibus_radr,
  output logic [15:0] ibus_rdata,
  input  logic        wen,
  input  logic [15:0] ibus_wadr,
  input  logic [15:0] ibus_wdata
);

  sys_state_e      state_q, state_d;
  logic [CntW-1:0] cntr_q, cntr_d;
  logic [CntW-1:0] drn_q, drn_d;
  logic [CntW-1:0] max_q, max_d;
  logic [CntW-1:0] run_q, run_d;
  logic [15:0]     rdata_q, rdata_d;
  logic            vld_q;
  logic [DataW-1:0] skew_a1_q, skew_b1_q;

  logic busy, start, clr, host_wen;
  logic [DataW-1:0] buf_rdata, ram_a0, ram_a1, ram_b0, ram_b1;
  logic [DataW-1:0] in_a0, in_a1, in_b0, in_b1;
  logic [DataW-1:0] a00, b00, b01, a10;
  logic [DataW-1:0] c00, c01, c10, c11;
  logic [DataW-1:0] pe01_a_unused, pe10_b_unused, pe11_a_unused, pe11_b_unused;

  assign busy     = (state_q != IDLE);
  assign host_wen = wen && !busy;
  assign start    = host_wen && (ibus_wadr == SYS_START_ADR);

  // Controller: IDLE -> FEED (addresses 0..max) -> DRAIN (run cycles) -> IDLE.
  always_comb begin
    state_d = state_q;
    cntr_d  = cntr_q;
    drn_d   = drn_q;
    clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FEED;
          cntr_d  = '0;
          clr     = 1'b1;
        end
      end
      FEED: begin
        if (cntr_q == max_q) begin
          if (run_q == '0) begin
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
            drn_d   = '0;
          end
        end else begin
          cntr_d = cntr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drn_q == run_q - 1'b1) begin
          state_d = IDLE;
        end else begin
          drn_d = drn_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Length and drain registers accept writes only while idle.
  always_comb begin
    max_d = max_q;
    run_d = run_q;
    if (host_wen && (ibus_wadr == SYS_MAX_CNTR)) max_d = ibus_wdata[CntW-1:0];
    if (host_wen && (ibus_wadr == SYS_RUN_CNTR)) run_d = ibus_wdata[CntW-1:0];
  end

  // Host read mux; the register holds its value when no read is requested.
  always_comb begin
    rdata_d = rdata_q;
    if (ren) begin
      rdata_d = buf_rdata;
      case (ibus_radr)
        SYS_START_ADR: rdata_d = {15'b0, busy};
        SYS_MAX_CNTR:  rdata_d = {8'b0, max_q};
        SYS_RUN_CNTR:  rdata_d = {8'b0, run_q};
        SYS_C00_ADR:   rdata_d = c00;
        SYS_C01_ADR:   rdata_d = c01;
        SYS_C10_ADR:   rdata_d = c10;
        SYS_C11_ADR:   rdata_d = c11;
        default:       ;
      endcase
    end
  end

  // RAM data is valid the cycle after a FEED address; otherwise PEs see zeros.
  assign in_a0 = vld_q ? ram_a0 : '0;
  assign in_a1 = vld_q ? ram_a1 : '0;
  assign in_b0 = vld_q ? ram_b0 : '0;
  assign in_b1 = vld_q ? ram_b1 : '0;

  // Controller, configuration, read-data and skew registers.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q   <= IDLE;
      cntr_q    <= '0;
      drn_q     <= '0;
      max_q     <= '0;
      run_q     <= '0;
      rdata_q   <= '0;
      vld_q     <= 1'b0;
      skew_a1_q <= '0;
      skew_b1_q <= '0;
    end else begin
      state_q   <= state_d;
      cntr_q    <= cntr_d;
      drn_q     <= drn_d;
      max_q     <= max_d;
      run_q     <= run_d;
      rdata_q   <= rdata_d;
      vld_q     <= (state_q == FEED);
      skew_a1_q <= clr ? '0 : in_a1;
      skew_b1_q <= clr ? '0 : in_b1;
    end
  end

  assign ibus_rdata = rdata_q;

  systolic4_iobuf iobuf (
    .clk_i        (clk),
    .wen_i        (host_wen),
    .wadr_i       (ibus_wadr),
    .wdata_i      (ibus_wdata),
    .radr_i       (ibus_radr),
    .host_rdata_o (buf_rdata),
    .feed_adr_i   (cntr_q),
    .a0_o         (ram_a0),
    .a1_o         (ram_a1),
    .b0_o         (ram_b0),
    .b1_o         (ram_b1)
  );

  systolic4_pe pe00 (
    .clk_i (clk),
    .rst_i (rst_n),
    .clr_i (clr),
    .en_i  (busy),
    .a_i   (in_a0),
    .b_i   (in_b0),
    .a_o   (a00),
    .b_o   (b00),
    .acc_o (c00)
  );

  systolic4_pe pe01 (
    .clk_i (clk),
    .rst_i (rst_n),
    .clr_i (clr),
    .en_i  (busy),
    .a_i   (a00),
    .b_i   (skew_b1_q),
    .a_o   (pe01_a_unused),
    .b_o   (b01),
    .acc_o (c01)
  );

  systolic4_pe pe10 (
    .clk_i (clk),
    .rst_i (rst_n),
    .clr_i (clr),
    .en_i  (busy),
    .a_i   (skew_a1_q),
    .b_i   (b00),
    .a_o   (a10),
    .b_o   (pe10_b_unused),
    .acc_o (c10)
  );

  systolic4_pe pe11 (
    .clk_i (clk),
    .rst_i (rst_n),
    .clr_i (clr),
    .en_i  (busy),
    .a_i   (a10),
    .b_i   (b01),
    .a_o   (pe11_a_unused),
    .b_o   (pe11_b_unused),
    .acc_o (c11)
  );

endmodule

// File: tb/tb_systolic_4.sv
// Directed self-checking bench for systolic_4.
module tb_systolic_4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ren, wen;
  logic [15:0] ibus_radr, ibus_wadr, ibus_wdata;
  logic [15:0] ibus_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  systolic_4 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ren        (ren),
    .ibus_radr  (ibus_radr),
    .ibus_rdata (ibus_rdata),
    .wen        (wen),
    .ibus_wadr  (ibus_wadr),
    .ibus_wdata (ibus_wdata)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    wen = 1'b1; ibus_wadr = a; ibus_wdata = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic rdchk(input string tag, input logic [15:0] a, input logic [15:0] exp);
    @(negedge clk);
    ren = 1'b1; ibus_radr = a;
    @(negedge clk);
    ren = 1'b0;
    chk(tag, ibus_rdata, exp);
  endtask

  // Write start, then poll busy every cycle; n = number of busy cycles seen.
  task automatic start_count(output int n);
    @(negedge clk);
    wen = 1'b1; ibus_wadr = 16'hFFF0; ibus_wdata = 16'h0001;
    @(negedge clk);
    wen = 1'b0; ren = 1'b1; ibus_radr = 16'hFFF0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ibus_rdata == 16'h0001) n++;
      else break;
    end
    ren = 1'b0;
  endtask

  task automatic check_basic(input string tag);
    rdchk({tag, "_c00"}, 16'hFFF4, 16'd4);
    rdchk({tag, "_c01"}, 16'hFFF5, 16'd6);
    rdchk({tag, "_c10"}, 16'hFFF6, 16'd12);
    rdchk({tag, "_c11"}, 16'hFFF7, 16'd14);
  endtask

  int n;

  initial begin
    rst_n = 1'b1; ren = 1'b1; wen = 1'b0;
    ibus_radr = 16'hFFF1; ibus_wadr = 16'h0; ibus_wdata = 16'h0;
    repeat (3) @(negedge clk);
    chk("rdata_in_reset", ibus_rdata, 16'h0000);
    ren = 1'b0; rst_n = 1'b0;

    // Reset state of the register window.
    for (int i = 0; i < 8; i++) rdchk("reset_reg", 16'hFFF0 + 16'(i), 16'h0000);

    // Preload operand vectors.
    for (int k = 0; k < 4; k++) begin
      wr(16'h0000 + 16'(k), 16'(k + 1));
      wr(16'h0100 + 16'(k), 16'(k + 5));
      wr(16'h0200 + 16'(k), (k % 2 == 0) ? 16'd1 : 16'd0);
      wr(16'h0300 + 16'(k), (k % 2 == 1) ? 16'd1 : 16'd0);
    end
    wr(16'h0005, 16'h00A5);

    // Buffer access and unmapped addresses.
    wr(16'h0105, 16'h1234);
    rdchk("buf_a1_5", 16'h0105, 16'h1234);
    rdchk("buf_a0_5", 16'h0005, 16'h00A5);
    rdchk("buf_b1_1", 16'h0301, 16'h0001);
    wr(16'hFFF3, 16'hBEEF);
    rdchk("unmapped_fff3", 16'hFFF3, 16'h0000);
    rdchk("unmapped_0400", 16'h0400, 16'h0000);

    // Same-cycle write and read of one address returns the old word.
    wr(16'h020A, 16'h1111);
    @(negedge clk);
    wen = 1'b1; ibus_wadr = 16'h020A; ibus_wdata = 16'h2222;
    ren = 1'b1; ibus_radr = 16'h020A;
    @(negedge clk);
    wen = 1'b0; ren = 1'b0;
    chk("rw_same_old", ibus_rdata, 16'h1111);
    rdchk("rw_same_new", 16'h020A, 16'h2222);

    // Basic run.
    wr(16'hFFF1, 16'd3);
    wr(16'hFFF2, 16'd4);
    rdchk("max_rb", 16'hFFF1, 16'd3);
    rdchk("run_rb", 16'hFFF2, 16'd4);
    start_count(n);
    chk("basic_busy_len", 16'(n), 16'd8);
    check_basic("basic");

    // Rerun clears accumulators first.
    start_count(n);
    chk("rerun_busy_len", 16'(n), 16'd8);
    check_basic("rerun");

    // Signed product and wrap, single-element vectors.
    wr(16'h0000, 16'hFFFF);
    wr(16'h0200, 16'h0003);
    wr(16'hFFF1, 16'd0);
    wr(16'hFFF2, 16'd3);
    start_count(n);
    chk("max0_busy_len", 16'(n), 16'd4);
    rdchk("signed_c00", 16'hFFF4, 16'hFFFD);
    wr(16'h0000, 16'h0100);
    wr(16'h0200, 16'h0100);
    start_count(n);
    rdchk("wrap_c00", 16'hFFF4, 16'h0000);
    wr(16'h0000, 16'h0001);
    wr(16'h0200, 16'h0001);

    // Writes while busy are ignored.
    wr(16'hFFF1, 16'd3);
    wr(16'hFFF2, 16'd4);
    @(negedge clk);
    wen = 1'b1; ibus_wadr = 16'hFFF0; ibus_wdata = 16'h0001;
    @(negedge clk);
    wen = 1'b0;
    wr(16'hFFF0, 16'h0001);
    wr(16'h0000, 16'h7777);
    wr(16'hFFF1, 16'h0000);
    repeat (12) @(negedge clk);
    rdchk("busy_done", 16'hFFF0, 16'h0000);
    check_basic("busywr");
    rdchk("busywr_buf", 16'h0000, 16'h0001);
    rdchk("busywr_max", 16'hFFF1, 16'd3);

    // Reset in the middle of FEED aborts the run.
    wr(16'hFFF0, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1; ren = 1'b1; ibus_radr = 16'hFFF0;
    @(negedge clk);
    chk("midrst_rdata", ibus_rdata, 16'h0000);
    rst_n = 1'b0; ren = 1'b0;
    rdchk("midrst_busy", 16'hFFF0, 16'h0000);
    rdchk("midrst_c00", 16'hFFF4, 16'h0000);
    rdchk("midrst_c11", 16'hFFF7, 16'h0000);
    rdchk("midrst_max", 16'hFFF1, 16'h0000);
    rdchk("midrst_buf", 16'h0102, 16'd7);
    wr(16'hFFF1, 16'd3);
    wr(16'hFFF2, 16'd4);
    start_count(n);
    chk("after_rst_busy_len", 16'(n), 16'd8);
    check_basic("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
